// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and constants for the ALU arbiter
// Contents: FSM state enum, ALU function-select codes, default data width,
// stats counter width and the wait-counter load helper.
package alu_arb_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int STAT_W = 16;
   localparam logic [1:0] ALU_OP_ADD = 2'b00;
   localparam logic [1:0] ALU_OP_AND = 2'b01;
   localparam logic [1:0] ALU_OP_OR  = 2'b10;
   localparam logic [1:0] ALU_OP_XOR = 2'b11;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   // The counter counts down to zero, so a latency of N loads N-1.
   function automatic logic [3:0] lat_load(input int lat);
      return 4'(lat - 1);
   endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant
// Ports: v0/v1 request valids, pri (1 = requester 1 holds priority),
// gnt one-hot grant (bit N for requester N). A lone valid wins regardless of pri.
module rr_arb2 (
   input  logic       v0,
   input  logic       v1,
   input  logic       pri,
   output logic [1:0] gnt
);
   assign gnt[0] = v0 & (~v1 | ~pri);
   assign gnt[1] = v1 & (~v0 | pri);
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two valid/ready requesters, round-robin
// Ports: clk, resetb (async, active low); req0_*/req1_* requester handshake
// and operands; R/S/CI/ALB_MI drive the ALU, F/CO come back after ALU_LAT
// cycles; rsp_* presents the captured result tagged with the requester id.
// Optional: define ALU_ARB_STATS_EN to add saturating per-requester accept
// counters grant_cnt0/grant_cnt1.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ALU_LAT = 1
) (
   input  logic              clk,
   input  logic              resetb,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_r,
   input  logic [DATA_W-1:0] req0_s,
   input  logic              req0_ci,
   input  logic [1:0]        req0_op,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_r,
   input  logic [DATA_W-1:0] req1_s,
   input  logic              req1_ci,
   input  logic [1:0]        req1_op,
   output logic [DATA_W-1:0] R,
   output logic [DATA_W-1:0] S,
   output logic              CI,
   output logic [1:0]        ALB_MI,
   input  logic [DATA_W-1:0] F,
   input  logic              CO,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_f,
   output logic              rsp_co
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0] grant_cnt0,
   output logic [STAT_W-1:0] grant_cnt1
`endif
);
   state_t     state, nxt;
   logic       pri;
   logic [3:0] cnt;
   logic [1:0] gnt;
   logic       acc;

   rr_arb2 u_arb (
      .v0  (req0_valid),
      .v1  (req1_valid),
      .pri (pri),
      .gnt (gnt)
   );

   // Readies are gated by resetb so they stay low while reset is held.
   assign req0_ready = resetb & (state == IDLE) & gnt[0];
   assign req1_ready = resetb & (state == IDLE) & gnt[1];
   assign acc        = req0_ready | req1_ready;
   assign rsp_valid  = state == RESP;

   always_comb begin
      nxt = state;
      nxt = state == IDLE ? (acc ? WAIT : IDLE) :
            state == WAIT ? (cnt == '0 ? RESP : WAIT) :
                            (rsp_ready ? IDLE : RESP);
   end

   always_ff @(posedge clk or negedge resetb)
      if (!resetb) state <= IDLE;
      else state <= nxt;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         pri    <= 1'b0;
         cnt    <= '0;
         R      <= '0;
         S      <= '0;
         CI     <= 1'b0;
         ALB_MI <= 2'b00;
         rsp_id <= 1'b0;
         rsp_f  <= '0;
         rsp_co <= 1'b0;
      end else begin
         if (acc) begin
            R      <= req1_ready ? req1_r  : req0_r;
            S      <= req1_ready ? req1_s  : req0_s;
            CI     <= req1_ready ? req1_ci : req0_ci;
            ALB_MI <= req1_ready ? req1_op : req0_op;
            rsp_id <= req1_ready;
            cnt    <= lat_load(ALU_LAT);
         end else if (state == WAIT) begin
            if (cnt == '0) begin
               rsp_f  <= F;
               rsp_co <= CO;
            end else cnt <= cnt - 4'd1;
         end
         // Hand priority to the requester that was not just served.
         if (state == RESP && rsp_ready) pri <= ~rsp_id;
      end
   end

`ifdef ALU_ARB_STATS_EN
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else begin
         if (req0_ready && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + STAT_W'(1);
         if (req1_ready && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + STAT_W'(1);
      end
   end
`endif
endmodule
